// File: rtl/mem_block_master_if.sv
// Memory-side bus of the block transfer master: one word access in flight,
// completed by a single-cycle i_mem_access pulse.
interface mem_block_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_data;
    logic                  o_mem_write_en;
    logic [DATA_WIDTH-1:0] i_mem_read_data;
    logic                  i_mem_access;

    modport master (
        output o_mem_addr,
        output o_mem_data,
        output o_mem_write_en,
        input  i_mem_read_data,
        input  i_mem_access
    );

    modport slave (
        input  o_mem_addr,
        input  o_mem_data,
        input  o_mem_write_en,
        output i_mem_read_data,
        output i_mem_access
    );
endinterface

// File: rtl/mem_block_master.sv
// Block transfer master: optionally writes back one block, then fills one block,
// one word per completed memory access.
module mem_block_master #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WORDS = 16
) (
    input  logic                           i_clk,
    input  logic                           i_arst,
    input  logic                           i_start,
    input  logic                           i_write_back,
    input  logic [ADDR_WIDTH-1:0]          i_wb_addr,
    input  logic [ADDR_WIDTH-1:0]          i_fill_addr,
    input  logic [DATA_WIDTH-1:0]          i_wb_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] o_wb_index,
    output logic [DATA_WIDTH-1:0]          o_fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] o_fill_index,
    output logic                           o_fill_valid,
    output logic                           o_busy,
    output logic                           o_done,
    mem_block_master_if.master             mem
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    // Clears the word-offset bits so both bases land on a block boundary.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << (IDX_W + 2)) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] wb_base_q, wb_base_d;
    logic [ADDR_WIDTH-1:0] fill_base_q, fill_base_d;
    logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
    logic [IDX_W-1:0]      fill_index_q, fill_index_d;
    logic                  fill_valid_q, fill_valid_d;

    logic                  last_word;
    logic [ADDR_WIDTH-1:0] word_offset;

    assign last_word   = (cnt_q == IDX_W'(BLOCK_WORDS - 1));
    assign word_offset = ADDR_WIDTH'({cnt_q, 2'b00});

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_d            = state_q;
        cnt_d              = cnt_q;
        wb_base_d          = wb_base_q;
        fill_base_d        = fill_base_q;
        fill_data_d        = fill_data_q;
        fill_index_d       = fill_index_q;
        fill_valid_d       = 1'b0;
        mem.o_mem_addr     = '0;
        mem.o_mem_data     = '0;
        mem.o_mem_write_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = i_write_back ? WB : FILL;
                    wb_base_d   = i_wb_addr & ALIGN_MASK;
                    fill_base_d = i_fill_addr & ALIGN_MASK;
                    cnt_d       = '0;
                end
            end
            WB: begin
                mem.o_mem_addr     = wb_base_q + word_offset;
                mem.o_mem_data     = i_wb_data;
                mem.o_mem_write_en = 1'b1;
                if (mem.i_mem_access) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (last_word) state_d = FILL;
                end
            end
            FILL: begin
                mem.o_mem_addr = fill_base_q + word_offset;
                if (mem.i_mem_access) begin
                    fill_data_d  = mem.i_mem_read_data;
                    fill_index_d = cnt_q;
                    fill_valid_d = 1'b1;
                    cnt_d        = cnt_q + IDX_W'(1);
                    if (last_word) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wb_base_q    <= '0;
            fill_base_q  <= '0;
            fill_data_q  <= '0;
            fill_index_q <= '0;
            fill_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wb_base_q    <= wb_base_d;
            fill_base_q  <= fill_base_d;
            fill_data_q  <= fill_data_d;
            fill_index_q <= fill_index_d;
            fill_valid_q <= fill_valid_d;
        end
    end

    assign o_wb_index   = cnt_q;
    assign o_fill_data  = fill_data_q;
    assign o_fill_index = fill_index_q;
    assign o_fill_valid = fill_valid_q;
    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);
endmodule

// File: doc/mem_block_master.md
MEM_BLOCK_MASTER -- requirements
Module: mem_block_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, memory word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 64, byte address width.
REQ-003 Parameter BLOCK_WORDS, default 16, words per block transfer; power of two, at least 2.
REQ-004 i_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_arst  input  1  reset, asynchronous, active-high.
REQ-006 i_start  input  1  request a block operation; sampled only in IDLE.
REQ-007 i_write_back  input  1  with i_start: write back a block before the fill.
REQ-008 i_wb_addr  input  ADDR_WIDTH  write-back block byte address.
REQ-009 i_fill_addr  input  ADDR_WIDTH  fill block byte address.
REQ-010 i_wb_data  input  DATA_WIDTH  write-back word for o_wb_index, valid in the same cycle.
REQ-011 o_wb_index  output  log2(BLOCK_WORDS)  current write-back word index.
REQ-012 o_fill_data  output  DATA_WIDTH  registered fill word.
REQ-013 o_fill_index  output  log2(BLOCK_WORDS)  index of o_fill_data.
REQ-014 o_fill_valid  output  1  one-cycle pulse: o_fill_data/o_fill_index valid.
REQ-015 o_busy  output  1  high whenever state is not IDLE.
REQ-016 o_done  output  1  one-cycle pulse: operation complete.
REQ-017 o_mem_addr  output  ADDR_WIDTH  memory byte address.
REQ-018 o_mem_data  output  DATA_WIDTH  memory write data.
REQ-019 o_mem_write_en  output  1  memory write enable.
REQ-020 i_mem_read_data  input  DATA_WIDTH  memory read data, combinational from o_mem_addr.
REQ-021 i_mem_access  input  1  memory completion pulse; the current access completes in any cycle where it is high.

Function
REQ-022 FSM states: IDLE, WB, FILL, DONE.
REQ-023 In IDLE, i_start=1 with i_write_back=1 -> WB; i_start=1 with i_write_back=0 -> FILL; otherwise stay in IDLE.
REQ-024 On leaving IDLE, latch both addresses with the low log2(BLOCK_WORDS)+2 bits forced to zero (block-aligned), and clear the word counter.
REQ-025 i_start and the address inputs are ignored outside IDLE.
REQ-026 o_mem_addr = latched base of the current state + counter*4; held stable until i_mem_access.
REQ-027 WB: o_mem_write_en=1; o_mem_data=i_wb_data; o_wb_index=counter (combinational).
REQ-028 FILL and all other states: o_mem_write_en=0; o_mem_data=0.
REQ-029 On i_mem_access in WB or FILL, the counter increments; at counter BLOCK_WORDS-1 it wraps to 0 and the state advances (WB->FILL, FILL->DONE).
REQ-030 On i_mem_access in FILL, the next cycle shows o_fill_data=i_mem_read_data, o_fill_index=counter and o_fill_valid=1.
REQ-031 o_fill_valid is 0 in every other cycle.
REQ-032 DONE lasts exactly one cycle with o_done=1, then returns to IDLE; o_busy=0 in that IDLE cycle.
REQ-033 o_done coincides with o_fill_valid for word BLOCK_WORDS-1.
REQ-034 i_mem_access in IDLE or DONE is ignored: no counter, state or output change.
REQ-035 Minimum latency (i_mem_access high every cycle): start sampled at cycle 0; a fill-only operation shows o_done at cycle BLOCK_WORDS+1; write-back+fill shows o_done at cycle 2*BLOCK_WORDS+1.

Reset
REQ-036 i_arst asserted at any time, including mid-operation, forces IDLE immediately and clears the counter, both latched addresses, o_fill_data, o_fill_index, o_fill_valid, o_done and o_busy to 0.
REQ-037 A partial transfer interrupted by reset is abandoned; the first operation after reset starts at index 0.

Verification
REQ-038 Fill-only: i_fill_addr=0x1000, i_mem_access always 1 -> o_mem_addr 0x1000..0x103C; 16 o_fill_valid pulses with o_fill_index 0..15; o_done at cycle 17.
REQ-039 Write-back+fill: wb 0x2000, fill 0x3000, i_wb_data=0xA500+index, memory delays from an 8-bit LFSR -> 16 writes 0xA500..0xA50F to 0x2000..0x203C, then 16 reads from 0x3000..; exactly one o_done.
REQ-040 Unaligned addresses: i_fill_addr=0x1047 -> first o_mem_addr=0x1040, last=0x107C.
REQ-041 i_start pulsed during FILL with different addresses -> no effect on the address sequence; exactly one o_done.
REQ-042 i_arst at fill word 5 -> all outputs 0 immediately; a new fill to 0x4000 begins at index 0, address 0x4000.
REQ-043 i_mem_access held 1 for 10 cycles in IDLE -> o_fill_valid, o_done and o_busy stay 0.
